// File: rtl/arbiter_pkg.sv
// Shared definitions for the requester front end and the one-hot arbiter:
// default sizing plus the grant-shape check used by both sides.
package arbiter_pkg;

  localparam int N_DEF            = 8;
  localparam int CW_DEF           = 4;
  localparam int TW_DEF           = 8;
  localparam int STARVE_LIMIT_DEF = 200;

  // Widest vector the shape check accepts; callers zero-extend into it.
  localparam int CHK_W = 64;

  // Sticky status bits owned by one request channel.
  typedef struct packed {
    logic overflow;
    logic starve;
  } chan_flags_t;

  // True when at most one bit of v is set (zero or one-hot).
  function automatic logic is_onehot0(input logic [CHK_W-1:0] v);
    return (v & (v - CHK_W'(1))) == '0;
  endfunction

endpackage

// File: rtl/arbiter_req_chan.sv
// One client's request channel: pending-request counter, wait-age counter,
// and the overflow / starvation sticky flags for that client.
module arbiter_req_chan
  import arbiter_pkg::*;
#(
  parameter int CW           = CW_DEF,
  parameter int TW           = TW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        push,
  input  logic        accept,
  input  logic        clear,
  output logic        request,
  output chan_flags_t flags
);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [TW-1:0] AGE_MAX   = '1;
  localparam logic [TW-1:0] AGE_LIMIT = TW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] age_q, age_d;
  logic          overflow_q, overflow_d;
  logic          starve_q, starve_d;
  logic          ovf_set;
  logic          starve_set;

  // Request is a pure decode of the registered count, so there is no
  // combinational path from push or grant back into the arbiter.
  assign request = (cnt_q != '0);

  // Pending count: push adds, accept removes; a push at full count with no
  // accept is dropped and flagged.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    case ({push, accept})
      2'b10: begin
        if (cnt_q == CNT_MAX) begin
          ovf_set = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      2'b01: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Wait age: counts cycles spent requesting without service, saturating.
  always_comb begin
    age_d      = '0;
    starve_set = 1'b0;
    if (request && !accept) begin
      age_d      = (age_q == AGE_MAX) ? age_q : age_q + 1'b1;
      starve_set = (age_d == AGE_LIMIT);
    end
  end

  // Sticky flags: a new set condition beats a simultaneous clear.
  always_comb begin
    overflow_d = (overflow_q & ~clear) | ovf_set;
    starve_d   = (starve_q & ~clear) | starve_set;
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q      <= '0;
      age_q      <= '0;
      overflow_q <= 1'b0;
      starve_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      age_q      <= age_d;
      overflow_q <= overflow_d;
      starve_q   <= starve_d;
    end
  end

  assign flags.overflow = overflow_q;
  assign flags.starve   = starve_q;

endmodule

// File: rtl/arbiter_requester.sv
// Requester-side front end for the fixed-priority one-hot arbiter.
// Turns per-client push pulses into level requests, validates the returned
// grant, and reports service, overflow, starvation and protocol errors.
module arbiter_requester
  import arbiter_pkg::*;
#(
  parameter int N            = N_DEF,
  parameter int CW           = CW_DEF,
  parameter int TW           = TW_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] push,
  input  logic         clear,
  output logic [N-1:0] request,
  input  logic [N-1:0] grant,
  output logic [N-1:0] served,
  output logic [N-1:0] overflow,
  output logic [N-1:0] starve,
  output logic         proto_err
);

  logic [N-1:0] accept;
  logic         grant_legal;
  logic [N-1:0] served_q, served_d;
  logic         proto_err_q, proto_err_d;
  chan_flags_t  chan_flags [N];

  // A grant is usable only if it is zero/one-hot and targets a requester;
  // otherwise the whole vector is discarded for this cycle.
  always_comb begin
    grant_legal = is_onehot0(CHK_W'(grant)) && ((grant & ~request) == '0);
    accept      = grant_legal ? (grant & request) : '0;
  end

  // Next-state for the served pulse and the sticky protocol-error flag.
  always_comb begin
    served_d    = accept;
    proto_err_d = (proto_err_q & ~clear) | ~grant_legal;
  end

  // Top-level registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      served_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      served_q    <= served_d;
      proto_err_q <= proto_err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      arbiter_req_chan #(
        .CW           (CW),
        .TW           (TW),
        .STARVE_LIMIT (STARVE_LIMIT)
      ) u_chan (
        .clk     (clk),
        .nreset  (nreset),
        .push    (push[gi]),
        .accept  (accept[gi]),
        .clear   (clear),
        .request (request[gi]),
        .flags   (chan_flags[gi])
      );
      assign overflow[gi] = chan_flags[gi].overflow;
      assign starve[gi]   = chan_flags[gi].starve;
    end
  endgenerate

  assign served    = served_q;
  assign proto_err = proto_err_q;

endmodule
